// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared types and opcode constants for the immediate stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_SH   = 3'd5,
        IMM_NONE = 3'd6
    } imm_type_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational opcode classification and immediate extraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_t       imm_type,
    output logic            illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_sh;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];

    // Size casts of signed operands sign-extend from instr[31] to XLEN.
    assign w_imm_i = XLEN'($signed(instr[31:20]));
    assign w_imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign w_imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    // Shift amount is unsigned; RV64 uses a 6-bit shamt, RV32 only 5 bits.
    assign w_imm_sh = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);

    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (w_opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_JALR, OPC_SYSTEM: imm_type = IMM_I;
            OPC_OP_IMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) imm_type = IMM_SH;
                else                                           imm_type = IMM_I;
            end
            OPC_STORE:         imm_type = IMM_S;
            OPC_BRANCH:        imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
            OPC_JAL:           imm_type = IMM_J;
            OPC_OP:            imm_type = IMM_NONE;
            default:           illegal  = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = w_imm_i;
            IMM_S:   imm = w_imm_s;
            IMM_B:   imm = w_imm_b;
            IMM_U:   imm = w_imm_u;
            IMM_J:   imm = w_imm_j;
            IMM_SH:  imm = w_imm_sh;
            default: imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_stage
//  Description : Elastic immediate-generation stage with an in-order buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_type_t       out_type,
    output logic            out_illegal
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);

    logic [XLEN-1:0]    w_dec_imm;
    imm_type_t          w_dec_type;
    logic               w_dec_illegal;
    logic               w_push;
    logic               w_pop;

    logic [XLEN-1:0]    r_imm  [DEPTH];
    imm_type_t          r_type [DEPTH];
    logic               r_ill  [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    imm_decode #(
        .XLEN     (XLEN)
    ) u_decode (
        .instr    (in_instr),
        .imm      (w_dec_imm),
        .imm_type (w_dec_type),
        .illegal  (w_dec_illegal)
    );

    // Ready depends only on occupancy, never on out_ready.
    assign in_ready  = (r_count < c_depth);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only visible while out_valid.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_imm[r_wr_ptr]  <= w_dec_imm;
            r_type[r_wr_ptr] <= w_dec_type;
            r_ill[r_wr_ptr]  <= w_dec_illegal;
        end
    end

    always_comb begin
        out_imm     = '0;
        out_type    = IMM_NONE;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_imm     = r_imm[r_rd_ptr];
            out_type    = r_type[r_rd_ptr];
            out_illegal = r_ill[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire
